// File: rtl/audio_pkg.sv
// Shared audio definitions: default sample width, sample type and I2S framing states.
package audio_pkg;

  localparam int SAMPLE_W_DEF = 16;

  typedef logic [SAMPLE_W_DEF-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sync_edge.sv
// N-stage synchronizer for the I2S pins with a BCLK rising-edge detector.
// lrck/sdin are tapped at the same depth as bclk so the three stay aligned.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic bclk,
  input  logic lrck,
  input  logic sdin,
  output logic bclk_rise,
  output logic lrck_s,
  output logic sdin_s
);

  logic [STAGES-1:0] bclk_q_r;
  logic [STAGES-1:0] lrck_q_r;
  logic [STAGES-1:0] sdin_q_r;
  logic              bclk_prev_r;

  // synchronizer chains plus previous bclk for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_q_r    <= '0;
      lrck_q_r    <= '0;
      sdin_q_r    <= '0;
      bclk_prev_r <= 1'b0;
    end else begin
      bclk_q_r    <= {bclk_q_r[STAGES-2:0], bclk};
      lrck_q_r    <= {lrck_q_r[STAGES-2:0], lrck};
      sdin_q_r    <= {sdin_q_r[STAGES-2:0], sdin};
      bclk_prev_r <= bclk_q_r[STAGES-1];
    end
  end

  assign bclk_rise = bclk_q_r[STAGES-1] & ~bclk_prev_r;
  assign lrck_s    = lrck_q_r[STAGES-1];
  assign sdin_s    = sdin_q_r[STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// Standard I2S stereo receiver: oversamples the codec pins, deserializes
// MSB-first slots and presents left/right pairs on a valid/ready interface.
module i2s_rx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W    = SAMPLE_W_DEF,
  parameter int SLOT_W_MAX  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i2s_bclk,
  input  logic                i2s_lrck,
  input  logic                i2s_sdin,
  output logic [SAMPLE_W-1:0] sample_left,
  output logic [SAMPLE_W-1:0] sample_right,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overflow,
  output logic                frame_err
);

  localparam int CNT_W = $clog2(SLOT_W_MAX + 2);
  localparam int SHW   = $clog2(SAMPLE_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_W_MAX + 1);

  logic rise_s, lrck_s, sdin_s, boundary_s;

  rx_state_t             state_r, state_n;
  logic                  lrck_prev_r, lrck_prev_n;
  logic [SAMPLE_W-1:0]   shreg_r, shreg_n, shreg_cap_s, word_s;
  logic [CNT_W-1:0]      bit_cnt_r, bit_cnt_n, cnt_cap_s;
  logic [SHW-1:0]        kept_s;
  logic [SAMPLE_W-1:0]   left_hold_r, left_hold_n, right_hold_r, right_hold_n;
  logic                  push_r, push_n, err_r, err_n;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .bclk      (i2s_bclk),
    .lrck      (i2s_lrck),
    .sdin      (i2s_sdin),
    .bclk_rise (rise_s),
    .lrck_s    (lrck_s),
    .sdin_s    (sdin_s)
  );

  // framing state and capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_SYNC;
      lrck_prev_r  <= 1'b0;
      shreg_r      <= '0;
      bit_cnt_r    <= '0;
      left_hold_r  <= '0;
      right_hold_r <= '0;
      push_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_n;
      lrck_prev_r  <= lrck_prev_n;
      shreg_r      <= shreg_n;
      bit_cnt_r    <= bit_cnt_n;
      left_hold_r  <= left_hold_n;
      right_hold_r <= right_hold_n;
      push_r       <= push_n;
      err_r        <= err_n;
    end
  end

  // bit capture and slot/frame sequencing on each BCLK rise
  always_comb begin
    state_n      = state_r;
    lrck_prev_n  = lrck_prev_r;
    shreg_n      = shreg_r;
    bit_cnt_n    = bit_cnt_r;
    left_hold_n  = left_hold_r;
    right_hold_n = right_hold_r;
    push_n       = 1'b0;
    err_n        = 1'b0;
    boundary_s   = (lrck_s != lrck_prev_r);
    // only the first SAMPLE_W bits of a slot are kept; short slots get zero-padded
    shreg_cap_s  = (bit_cnt_r < CNT_W'(SAMPLE_W)) ? {shreg_r[SAMPLE_W-2:0], sdin_s} : shreg_r;
    cnt_cap_s    = (bit_cnt_r == CNT_MAX) ? bit_cnt_r : bit_cnt_r + CNT_W'(1);
    kept_s       = (cnt_cap_s >= CNT_W'(SAMPLE_W)) ? SHW'(SAMPLE_W) : SHW'(cnt_cap_s);
    word_s       = shreg_cap_s << (SHW'(SAMPLE_W) - kept_s);
    if (rise_s) begin
      lrck_prev_n = lrck_s;
      case (state_r)
        ST_SYNC: begin
          if (boundary_s && !lrck_s) begin
            shreg_n   = '0;
            bit_cnt_n = '0;
            state_n   = ST_LEFT;
          end else begin
            state_n = ST_SYNC;
          end
        end
        ST_LEFT, ST_RIGHT: begin
          if (cnt_cap_s == CNT_MAX) begin
            err_n     = 1'b1;
            shreg_n   = '0;
            bit_cnt_n = '0;
            state_n   = ST_SYNC;
          end else if (!boundary_s) begin
            shreg_n   = shreg_cap_s;
            bit_cnt_n = cnt_cap_s;
          end else if (state_r == ST_LEFT && lrck_s) begin
            left_hold_n = word_s;
            shreg_n     = '0;
            bit_cnt_n   = '0;
            state_n     = ST_RIGHT;
          end else if (state_r == ST_RIGHT && !lrck_s) begin
            right_hold_n = word_s;
            push_n       = 1'b1;
            shreg_n      = '0;
            bit_cnt_n    = '0;
            state_n      = ST_LEFT;
          end else begin
            err_n     = 1'b1;
            shreg_n   = '0;
            bit_cnt_n = '0;
            state_n   = ST_SYNC;
          end
        end
        default: begin
          shreg_n   = '0;
          bit_cnt_n = '0;
          state_n   = ST_SYNC;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // output holding register with valid/ready handshake and overflow detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      overflow     <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      frame_err <= err_r;
      if (push_r) begin
        if (!sample_valid || sample_ready) begin
          sample_left  <= left_hold_r;
          sample_right <= right_hold_r;
          sample_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (sample_ready) begin
        sample_valid <= 1'b0;
      end else begin
        sample_valid <= sample_valid;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives I2S frames at BCLK = clk/8 and checks
// received pairs, latency, overflow, frame errors and mid-frame reset.
module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i2s_bclk = 1'b0;
  logic        i2s_lrck = 1'b0;
  logic        i2s_sdin = 1'b0;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic        overflow;
  logic        frame_err;

  int total = 0;
  int bad   = 0;
  int err_cnt = 0;
  int ov_cnt  = 0;

  i2s_rx dut (
    .clk          (clk),
    .rst          (rst),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdin     (i2s_sdin),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overflow     (overflow),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // pulse counters for the one-cycle status outputs
  always @(negedge clk) begin
    if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
    if (overflow === 1'b1)  ov_cnt  <= ov_cnt + 1;
  end

  task automatic do_reset();
    rst = 1'b1;
    i2s_bclk = 1'b0;
    i2s_lrck = 1'b0;
    i2s_sdin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // one BCLK period: data/lrck change with bclk low, captured on the rise
  task automatic send_bit(input logic lr, input logic d);
    @(negedge clk);
    i2s_bclk = 1'b0;
    i2s_lrck = lr;
    i2s_sdin = d;
    repeat (3) @(negedge clk);
    @(negedge clk);
    i2s_bclk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // slot of n bits MSB first; the LSB goes out with the next slot's lrck
  task automatic send_slot(input logic [63:0] w, input int n, input logic lr, input logic lr_next);
    for (int i = n - 1; i >= 0; i--) send_bit((i == 0) ? lr_next : lr, w[i]);
  endtask

  task automatic send_frame(input logic [63:0] l, input logic [63:0] r, input int n);
    send_slot(l, n, 1'b0, 1'b1);
    send_slot(r, n, 1'b1, 1'b0);
  endtask

  task automatic preamble();
    send_slot(64'h0, 4, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    total += 5;
    if (sample_left !== 16'h0000) begin bad++; $display("FAIL reset_left: got %h want 0000", sample_left); end
    if (sample_right !== 16'h0000) begin bad++; $display("FAIL reset_right: got %h want 0000", sample_right); end
    if (sample_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
  endtask

  task automatic test_16bit_latency();
    logic [15:0] r;
    r = 16'hABCD;
    do_reset();
    sample_ready = 1'b1;
    preamble();
    send_slot(64'h1234, 16, 1'b0, 1'b1);
    for (int i = 15; i >= 1; i--) send_bit(1'b1, r[i]);
    @(negedge clk);
    i2s_bclk = 1'b0;
    i2s_lrck = 1'b0;
    i2s_sdin = r[0];
    repeat (3) @(negedge clk);
    @(negedge clk);
    i2s_bclk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (sample_valid !== 1'b0) begin bad++; $display("FAIL lat16_early: valid got %b want 0 after 3 clk", sample_valid); end
    @(posedge clk);
    #1;
    total += 3;
    if (sample_valid !== 1'b1) begin bad++; $display("FAIL lat16_valid: valid got %b want 1 after 4 clk", sample_valid); end
    if (sample_left !== 16'h1234) begin bad++; $display("FAIL lat16_left: got %h want 1234", sample_left); end
    if (sample_right !== 16'hABCD) begin bad++; $display("FAIL lat16_right: got %h want abcd", sample_right); end
    @(posedge clk);
    #1;
    total++;
    if (sample_valid !== 1'b0) begin bad++; $display("FAIL lat16_drop: valid got %b want 0 after transfer", sample_valid); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_32bit();
    int e0;
    do_reset();
    sample_ready = 1'b0;
    e0 = err_cnt;
    preamble();
    send_frame(64'h8001FFFF, 64'h7FFE0000, 32);
    repeat (4) @(negedge clk);
    total += 4;
    if (sample_valid !== 1'b1) begin bad++; $display("FAIL s32_valid: got %b want 1", sample_valid); end
    if (sample_left !== 16'h8001) begin bad++; $display("FAIL s32_left: got %h want 8001", sample_left); end
    if (sample_right !== 16'h7FFE) begin bad++; $display("FAIL s32_right: got %h want 7ffe", sample_right); end
    if (err_cnt - e0 !== 0) begin bad++; $display("FAIL s32_frame_err: got %0d pulses want 0", err_cnt - e0); end
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
  endtask

  task automatic test_8bit();
    do_reset();
    sample_ready = 1'b0;
    preamble();
    send_frame(64'hA5, 64'h5A, 8);
    repeat (4) @(negedge clk);
    total += 3;
    if (sample_valid !== 1'b1) begin bad++; $display("FAIL s8_valid: got %b want 1", sample_valid); end
    if (sample_left !== 16'hA500) begin bad++; $display("FAIL s8_left: got %h want a500", sample_left); end
    if (sample_right !== 16'h5A00) begin bad++; $display("FAIL s8_right: got %h want 5a00", sample_right); end
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int o0;
    do_reset();
    sample_ready = 1'b0;
    o0 = ov_cnt;
    preamble();
    send_frame(64'h1111, 64'h2222, 16);
    send_frame(64'h3333, 64'h4444, 16);
    send_frame(64'h5555, 64'h6666, 16);
    repeat (4) @(negedge clk);
    total += 4;
    if (sample_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid: got %b want 1", sample_valid); end
    if (sample_left !== 16'h1111) begin bad++; $display("FAIL ovf_left: got %h want 1111", sample_left); end
    if (sample_right !== 16'h2222) begin bad++; $display("FAIL ovf_right: got %h want 2222", sample_right); end
    if (ov_cnt - o0 !== 2) begin bad++; $display("FAIL ovf_pulses: got %0d want 2", ov_cnt - o0); end
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    total++;
    if (sample_valid !== 1'b0) begin bad++; $display("FAIL ovf_release: valid got %b want 0", sample_valid); end
  endtask

  task automatic test_frame_err();
    int e0;
    do_reset();
    sample_ready = 1'b0;
    e0 = err_cnt;
    preamble();
    send_slot(64'h00F0_F0F0_F0F0, 40, 1'b0, 1'b1);
    send_slot(64'h1111, 16, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    total += 2;
    if (err_cnt - e0 !== 1) begin bad++; $display("FAIL ferr_pulses: got %0d want 1", err_cnt - e0); end
    if (sample_valid !== 1'b0) begin bad++; $display("FAIL ferr_no_output: valid got %b want 0", sample_valid); end
    send_frame(64'h1357, 64'h2468, 16);
    repeat (4) @(negedge clk);
    total += 4;
    if (sample_valid !== 1'b1) begin bad++; $display("FAIL ferr_next_valid: got %b want 1", sample_valid); end
    if (sample_left !== 16'h1357) begin bad++; $display("FAIL ferr_next_left: got %h want 1357", sample_left); end
    if (sample_right !== 16'h2468) begin bad++; $display("FAIL ferr_next_right: got %h want 2468", sample_right); end
    if (err_cnt - e0 !== 1) begin bad++; $display("FAIL ferr_total: got %0d want 1", err_cnt - e0); end
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] r;
    r = 16'h9999;
    do_reset();
    sample_ready = 1'b0;
    preamble();
    send_frame(64'h1111, 64'h2222, 16);
    send_slot(64'h3333, 16, 1'b0, 1'b1);
    for (int i = 15; i >= 8; i--) send_bit(1'b1, r[i]);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total += 3;
    if (sample_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", sample_valid); end
    if (sample_left !== 16'h0000) begin bad++; $display("FAIL rmid_left: got %h want 0000", sample_left); end
    if (sample_right !== 16'h0000) begin bad++; $display("FAIL rmid_right: got %h want 0000", sample_right); end
    for (int i = 7; i >= 1; i--) send_bit(1'b1, r[i]);
    send_bit(1'b0, r[0]);
    repeat (4) @(negedge clk);
    total++;
    if (sample_valid !== 1'b0) begin bad++; $display("FAIL rmid_partial: valid got %b want 0", sample_valid); end
    send_frame(64'h0F0F, 64'hF0F0, 16);
    repeat (4) @(negedge clk);
    total += 3;
    if (sample_valid !== 1'b1) begin bad++; $display("FAIL rmid_next_valid: got %b want 1", sample_valid); end
    if (sample_left !== 16'h0F0F) begin bad++; $display("FAIL rmid_next_left: got %h want 0f0f", sample_left); end
    if (sample_right !== 16'hF0F0) begin bad++; $display("FAIL rmid_next_right: got %h want f0f0", sample_right); end
  endtask

  initial begin
    test_reset();
    test_16bit_latency();
    test_32bit();
    test_8bit();
    test_overflow();
    test_frame_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
